shift_rotate_unit: RTL and testbench

- Parametrised, multi-cycle shift/rotate unit for the datapath ALU. Replaces the fixed 32-bit combinational rotate.
- Supports logical right, arithmetic right, logical left, rotate right and rotate left.
- Works one log2 stage per clock: stage k shifts by 2^k when amount bit k is set.
- Start/busy/done handshake to the control unit; the result is held until the next accepted start.

---
 rtl/shift_rotate_unit.sv | 112 +++++++++++
 tb/tb_shift_rotate_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit: one log2 stage per clock, start/busy/done handshake.
// Optional macro SHIFT_EARLY_EXIT_EN finishes once no higher amount bits remain.
module shift_rotate_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0]   WL         = (SHW+1)'(WIDTH);
  localparam logic [SHW-1:0] LAST_STAGE = (SHW)'(SHW-1);

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_next_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_data, r_result;
  logic [SHW-1:0]   r_amt, r_cnt;

  logic             w_accept, w_last, w_over, w_is_shift;
  logic [WIDTH-1:0] w_lat_data, w_shifted, w_stage;
  logic [SHW-1:0]   w_lat_amt;
  logic [SHW:0]     w_sh, w_rsh;

  assign w_accept   = start && (r_state != S_SHIFT);
  assign w_over     = |amount[WIDTH-1:SHW];
  assign w_is_shift = (op == OP_SHR) || (op == OP_SHRA) || (op == OP_SHL);

  // Oversized shifts collapse to the fill value so the stages just pass it through.
  always_comb begin
    w_lat_data = data_in;
    w_lat_amt  = amount[SHW-1:0];
    if (w_is_shift && w_over) begin
      w_lat_data = (op == OP_SHRA) ? {WIDTH{data_in[WIDTH-1]}} : '0;
      w_lat_amt  = '0;
    end
  end

  assign w_sh  = (SHW+1)'(1) << r_cnt;
  assign w_rsh = WL - w_sh;

  always_comb begin
    w_shifted = r_data;
    case (r_op)
      OP_SHR:  w_shifted = r_data >> w_sh;
      OP_SHRA: w_shifted = $signed(r_data) >>> w_sh;
      OP_SHL:  w_shifted = r_data << w_sh;
      OP_ROR:  w_shifted = (r_data >> w_sh) | (r_data << w_rsh);
      OP_ROL:  w_shifted = (r_data << w_sh) | (r_data >> w_rsh);
      default: w_shifted = r_data;
    endcase
  end

  assign w_stage = r_amt[r_cnt] ? w_shifted : r_data;

`ifdef SHIFT_EARLY_EXIT_EN
  assign w_last = (r_cnt == LAST_STAGE) || (((r_amt >> r_cnt) >> 1) == '0);
`else
  assign w_last = (r_cnt == LAST_STAGE);
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_SHIFT;
      S_SHIFT: if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = start ? S_SHIFT : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_op     <= '0;
      r_data   <= '0;
      r_amt    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op   <= op;
      r_data <= w_lat_data;
      r_amt  <= w_lat_amt;
      r_cnt  <= '0;
    end else if (r_state == S_SHIFT) begin
      r_data <= w_stage;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) r_result <= w_stage;
    end
  end

  assign busy   = (r_state == S_SHIFT);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed self-checking bench for shift_rotate_unit (WIDTH=32).
module tb_shift_rotate_unit;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] data_in = '0;
  logic [31:0] amount = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  shift_rotate_unit #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .data_in(data_in),
    .amount(amount), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Drives one request (called 1 time unit after a rising edge), returns cycles to done.
  task automatic do_op(input logic [2:0] o, input logic [31:0] d, input logic [31:0] a,
                       output int lat, output logic busy_acc, output logic [31:0] res);
    op = o; data_in = d; amount = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_acc = busy;
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    res = result;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
    end
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_op(input string nm, input logic [2:0] o, input logic [31:0] d,
                          input logic [31:0] a, input logic [31:0] exp,
                          input int lat_def, input int lat_ee);
    int lat, exp_lat; logic b; logic [31:0] r;
`ifdef SHIFT_EARLY_EXIT_EN
    exp_lat = lat_ee;
`else
    exp_lat = lat_def;
`endif
    do_op(o, d, a, lat, b, r);
    checks++;
    if (r !== exp) begin
      errors++;
      $display("FAIL %s result: got %h, required %h", nm, r, exp);
    end
    checks++;
    if (lat != exp_lat || b !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d busy=%b, required %0d busy=1", nm, lat, b, exp_lat);
    end
    idle_cycle();
  endtask

  task automatic test_rotate();
    check_op("ror_1",      3'b011, 32'h0000_0001, 32'd1,  32'h8000_0000, 5, 1);
    check_op("ror_5",      3'b011, 32'h0040_0000, 32'd5,  32'h0002_0000, 5, 3);
    check_op("rol_33",     3'b100, 32'h8000_0001, 32'd33, 32'h0000_0003, 5, 1);
    check_op("ror_0",      3'b011, 32'h1234_5678, 32'd0,  32'h1234_5678, 5, 1);
  endtask

  task automatic test_shift();
    check_op("shra_4",     3'b001, 32'h8000_0000, 32'd4,  32'hF800_0000, 5, 3);
    check_op("shra_40",    3'b001, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 5, 1);
    check_op("shl_32",     3'b010, 32'hFFFF_FFFF, 32'd32, 32'h0000_0000, 5, 1);
    check_op("shr_31",     3'b000, 32'hF000_0000, 32'd31, 32'h0000_0001, 5, 5);
    check_op("shl_16",     3'b010, 32'h0000_0001, 32'd16, 32'h0001_0000, 5, 5);
  endtask

  task automatic test_passthru();
    check_op("op110",      3'b110, 32'hDEAD_BEEF, 32'd3,  32'hDEAD_BEEF, 5, 2);
  endtask

  task automatic test_busy_ignore();
    int lat = 99;
    op = 3'b011; data_in = 32'h0000_0001; amount = 32'd16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 2) begin op = 3'b010; data_in = 32'hFFFF_FFFF; amount = 32'd4; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    start = 1'b0;
    checks++;
    if (result !== 32'h0001_0000 || lat != 5) begin
      errors++;
      $display("FAIL busy_ignore: result=%h lat=%0d, required 00010000 lat=5", result, lat);
    end
    idle_cycle();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_no_queue: busy=%b done=%b, required 0 0", busy, done);
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int lat, exp_lat; logic b; logic [31:0] r;
    logic [31:0] mid;
`ifdef SHIFT_EARLY_EXIT_EN
    exp_lat = 3;
`else
    exp_lat = 5;
`endif
    do_op(3'b011, 32'h0000_0002, 32'd1, lat, b, r);
    checks++;
    if (r !== 32'h0000_0001) begin
      errors++;
      $display("FAIL b2b_first: got %h, required 00000001", r);
    end
    // Still inside the done cycle: issue the second request.
    op = 3'b010; data_in = 32'h0000_0001; amount = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mid = result;
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1 && !done) mid = result;
      if (done) begin lat = n; break; end
    end
    checks++;
    if (mid !== 32'h0000_0001) begin
      errors++;
      $display("FAIL b2b_hold: result during op=%h, required 00000001", mid);
    end
    checks++;
    if (result !== 32'h0000_0010 || lat != exp_lat) begin
      errors++;
      $display("FAIL b2b_second: result=%h lat=%0d, required 00000010 lat=%0d", result, lat, exp_lat);
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    int lat; logic b; logic [31:0] r;
    logic saw_done = 1'b0;
    op = 3'b011; data_in = 32'h0000_0001; amount = 32'd16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    clr = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
    end
    repeat (3) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    clr = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_done: done seen=%b, required 0", saw_done);
    end
    do_op(3'b011, 32'h0000_0002, 32'd1, lat, b, r);
    checks++;
    if (r !== 32'h0000_0001) begin
      errors++;
      $display("FAIL reset_mid_after: got %h, required 00000001", r);
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_shift();
    test_passthru();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
